mux_nx1_skid: RTL and testbench

// - Parametrised N:1 W-bit multiplexer with a registered, back-pressured output (2-entry skid buffer).
// - Used in the CORDIC exponential datapath to select initial vs. iterated X/Y/Z and LUT operands.
// - Lets a stalled downstream stage hold the pipeline without losing a selected word.
// - Adds range checking of the selector with a sticky error flag.

---
 rtl/mux_nx1_skid_pkg.sv | 14 +
 rtl/mux_nx1_comb.sv | 26 ++
 rtl/mux_nx1_skid.sv | 109 ++++++++++
 tb/tb_mux_nx1_skid.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_nx1_skid_pkg.sv
// Shared definitions for the CORDIC exponential datapath muxes: widths and
// skid-buffer state encodings.
package mux_nx1_skid_pkg;

    localparam int W_FRAC = 23;
    localparam int W_FULL = 32;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/mux_nx1_comb.sv
// Pure N:1 W-bit selector; an out-of-range index yields channel 0 and raises
// o_range_err.
module mux_nx1_comb #(
    parameter int W    = 23,
    parameter int N    = 4,
    parameter int SELW = 2
) (
    input  logic [SELW-1:0] i_sel,
    input  logic [N*W-1:0]  i_d_in,
    output logic [W-1:0]    o_word,
    output logic            o_range_err
);

    // Matching only indices below N makes the flag fold to 0 when N == 2**SELW.
    always_comb begin
        o_word      = i_d_in[W-1:0];
        o_range_err = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (i_sel == SELW'(k)) begin
                o_word      = i_d_in[k*W +: W];
                o_range_err = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_nx1_skid.sv
// N:1 multiplexer with a registered, back-pressured output held in a
// 2-entry skid buffer (main M drives d_out, skid S takes the overflow word).
module mux_nx1_skid
    import mux_nx1_skid_pkg::*;
#(
    parameter int           W       = W_FRAC,
    parameter int           N       = 4,
    parameter int           SELW    = 2,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SELW-1:0] sel,
    input  logic [N*W-1:0]  d_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    d_out,
    output logic            sel_err,
    input  logic            clr_err
);

    skid_state_t r_state;
    logic [W-1:0] r_m;
    logic [W-1:0] r_s;
    logic         r_in_ready;
    logic         r_out_valid;
    logic         r_sel_err;

    logic [W-1:0] w_word;
    logic         w_range_err;
    logic         w_accept;
    logic         w_emit;

    mux_nx1_comb #(
        .W    (W),
        .N    (N),
        .SELW (SELW)
    ) u_sel (
        .i_sel       (sel),
        .i_d_in      (d_in),
        .o_word      (w_word),
        .o_range_err (w_range_err)
    );

    assign w_accept = in_valid & r_in_ready;
    assign w_emit   = r_out_valid & out_ready;

    // in_ready stays low while in reset and rises on the first clock after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_EMPTY;
            r_m         <= RST_VAL;
            r_s         <= RST_VAL;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_sel_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_m         <= w_word;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_emit) begin
                        r_m <= w_word;
                    end else if (w_accept) begin
                        r_s        <= w_word;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_FULL;
                    end else if (w_emit) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_emit) begin
                        r_m        <= r_s;
                        r_in_ready <= 1'b1;
                        r_state    <= ST_ONE;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase

            // A set on this cycle's accept takes priority over clr_err.
            if (w_accept && w_range_err) begin
                r_sel_err <= 1'b1;
            end else if (clr_err) begin
                r_sel_err <= 1'b0;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign d_out     = r_m;
    assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_mux_nx1_skid.sv
// Directed and random checks of mux_nx1_skid with W=23, N=3, SELW=2.
module tb_mux_nx1_skid;

    localparam int W    = 23;
    localparam int N    = 3;
    localparam int SELW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [SELW-1:0] sel;
    logic [N*W-1:0]  d_in;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    d_out;
    logic            sel_err;
    logic            clr_err;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] q[$];
    logic [W-1:0] exp_word;
    logic [W-1:0] ch0, ch1, ch2;
    logic         acc, emt;

    mux_nx1_skid #(
        .W       (W),
        .N       (N),
        .SELW    (SELW),
        .RST_VAL ('0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .d_in      (d_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d_out     (d_out),
        .sel_err   (sel_err),
        .clr_err   (clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input logic [W-1:0] c0, input logic [W-1:0] c1, input logic [W-1:0] c2);
        d_in = {c2, c1, c0};
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; sel = '0; d_in = '0; out_ready = 1'b0; clr_err = 1'b0;
        #22;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_d_out", 32'(d_out), 32'd0);
        rst = 1'b1;
        step();
        step();
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_d_out", 32'(d_out), 32'd0);
        chk("idle_sel_err", 32'(sel_err), 32'd0);

        // Streaming at one word per cycle
        set_ch(23'h000001, 23'h000002, 23'h000003);
        in_valid = 1'b1; out_ready = 1'b1; sel = 2'd0;
        step();
        chk("stream0_valid", 32'(out_valid), 32'd1);
        chk("stream0", 32'(d_out), 32'h000001);
        sel = 2'd1;
        step();
        chk("stream1", 32'(d_out), 32'h000002);
        sel = 2'd2;
        step();
        chk("stream2", 32'(d_out), 32'h000003);
        chk("stream2_err", 32'(sel_err), 32'd0);
        in_valid = 1'b0;
        step();
        chk("stream_drained", 32'(out_valid), 32'd0);
        chk("stream_hold_last", 32'(d_out), 32'h000003);

        // Back-pressure fills the skid register
        out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
        set_ch(23'h0AAAAA, 23'h0, 23'h0);
        step();
        chk("bp_a", 32'(d_out), 32'h0AAAAA);
        chk("bp_ready_one", 32'(in_ready), 32'd1);
        set_ch(23'h055555, 23'h0, 23'h0);
        step();
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        chk("bp_hold_a", 32'(d_out), 32'h0AAAAA);
        set_ch(23'h7FFFFF, 23'h0, 23'h0);
        step();
        chk("bp_still_a", 32'(d_out), 32'h0AAAAA);
        chk("bp_still_full", 32'(in_ready), 32'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("bp_b", 32'(d_out), 32'h055555);
        chk("bp_b_valid", 32'(out_valid), 32'd1);
        step();
        chk("bp_empty", 32'(out_valid), 32'd0);
        chk("bp_empty_ready", 32'(in_ready), 32'd1);

        // Out-of-range selector
        set_ch(23'h000011, 23'h000022, 23'h000033);
        in_valid = 1'b1; sel = 2'd3;
        step();
        chk("range_word", 32'(d_out), 32'h000011);
        chk("range_err_set", 32'(sel_err), 32'd1);
        in_valid = 1'b0;
        step();
        chk("range_sticky", 32'(sel_err), 32'd1);
        in_valid = 1'b1; clr_err = 1'b1;
        step();
        chk("range_set_wins", 32'(sel_err), 32'd1);
        in_valid = 1'b0;
        step();
        chk("range_cleared", 32'(sel_err), 32'd0);
        clr_err = 1'b0;
        step();

        // Asynchronous reset while FULL
        out_ready = 1'b0; in_valid = 1'b1;
        set_ch(23'h0, 23'h000123, 23'h000456);
        sel = 2'd1;
        step();
        sel = 2'd2;
        step();
        chk("mid_full", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_d_out", 32'(d_out), 32'd0);
        #1;
        rst = 1'b1;
        step();
        chk("mid_ready_back", 32'(in_ready), 32'd1);
        chk("mid_no_stale", 32'(out_valid), 32'd0);
        set_ch(23'h000321, 23'h0, 23'h0);
        in_valid = 1'b1; sel = 2'd0; out_ready = 1'b1;
        step();
        chk("mid_new_word", 32'(d_out), 32'h000321);
        in_valid = 1'b0;
        step();
        chk("mid_only_new", 32'(out_valid), 32'd0);

        // Random traffic against an in-order scoreboard
        q.delete();
        for (int i = 0; i < 4000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            sel       = SELW'($urandom_range(0, 3));
            ch0 = W'($urandom); ch1 = W'($urandom); ch2 = W'($urandom);
            set_ch(ch0, ch1, ch2);
            case (sel)
                2'd1:    exp_word = ch1;
                2'd2:    exp_word = ch2;
                default: exp_word = ch0;
            endcase
            chk("rnd_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("rnd_ready", 32'(in_ready), 32'(q.size() < 2));
            acc = in_valid & in_ready;
            emt = out_valid & out_ready;
            if (emt) begin
                if (q.size() == 0) chk("rnd_underflow", 32'd1, 32'd0);
                else chk("rnd_data", 32'(d_out), 32'(q.pop_front()));
            end
            if (acc) q.push_back(exp_word);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (out_valid) begin
                if (q.size() == 0) chk("drain_extra", 32'd1, 32'd0);
                else chk("drain_data", 32'(d_out), 32'(q.pop_front()));
            end
            step();
        end
        chk("drain_count", 32'(q.size()), 32'd0);
        chk("drain_valid", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
